ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard, using the host-request-to-send protocol over the shared open-drain ps2clk/ps2data lines. It sits beside the PS/2 keyboard receiver under the top-level. While `busy` is high, the top-level must hold the receiver quiet. The top-level drives each pad low when the matching `_oe` is 1 and leaves it at high-Z otherwise.

---
 rtl/ps2_host_tx.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send and
// clocks one command byte (odd parity, stop bit, device ACK) out on device clock edges.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 50,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_BITS,
    S_ACK,
    S_WAIT_IDLE,
    S_FINISH
  } state_t;

  localparam int MAX_A   = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int MAX_CNT = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int FLT_W   = $clog2(FILTER_CYCLES + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST   = FLT_W'(FILTER_CYCLES - 1);

  typedef struct packed {
    logic             lvl;
    logic [FLT_W-1:0] cnt;
  } flt_t;

  // A new level is accepted only after FILTER_CYCLES consecutive differing samples.
  function automatic flt_t flt_step(input flt_t cur, input logic smp);
    flt_t nxt;
    nxt = cur;
    if (smp == cur.lvl) begin
      nxt.cnt = '0;
    end else if (cur.cnt == FLT_LAST) begin
      nxt.lvl = smp;
      nxt.cnt = '0;
    end else begin
      nxt.cnt = cur.cnt + 1'b1;
    end
    return nxt;
  endfunction

  logic ps2clk_p0_q, ps2clk_p0_d, ps2clk_p1_q, ps2clk_p1_d;
  logic ps2data_p0_q, ps2data_p0_d, ps2data_p1_q, ps2data_p1_d;
  flt_t clk_flt_q, clk_flt_d, dat_flt_q, dat_flt_d;
  logic fall_q, fall_d;

  always_comb begin
    ps2clk_p0_d  = ps2clk_in;
    ps2clk_p1_d  = ps2clk_p0_q;
    ps2data_p0_d = ps2data_in;
    ps2data_p1_d = ps2data_p0_q;
    clk_flt_d    = flt_step(clk_flt_q, ps2clk_p1_q);
    dat_flt_d    = flt_step(dat_flt_q, ps2data_p1_q);
    fall_d       = clk_flt_q.lvl & ~clk_flt_d.lvl;
  end

  // p0/p1: two-flop synchronizer, then stable-level filter and fall strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2clk_p0_q  <= 1'b1;
      ps2clk_p1_q  <= 1'b1;
      ps2data_p0_q <= 1'b1;
      ps2data_p1_q <= 1'b1;
      clk_flt_q    <= '{lvl: 1'b1, cnt: '0};
      dat_flt_q    <= '{lvl: 1'b1, cnt: '0};
      fall_q       <= 1'b0;
    end else begin
      ps2clk_p0_q  <= ps2clk_p0_d;
      ps2clk_p1_q  <= ps2clk_p1_d;
      ps2data_p0_q <= ps2data_p0_d;
      ps2data_p1_q <= ps2data_p1_d;
      clk_flt_q    <= clk_flt_d;
      dat_flt_q    <= dat_flt_d;
      fall_q       <= fall_d;
    end
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             ps2clk_oe_q, ps2clk_oe_d;
  logic             ps2data_oe_q, ps2data_oe_d;
  logic             busy_q, busy_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_error_q, tx_error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             cur_bit;
  logic             timed;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    data_d       = data_q;
    par_d        = par_q;
    ps2clk_oe_d  = ps2clk_oe_q;
    ps2data_oe_d = ps2data_oe_q;
    busy_d       = busy_q;
    tx_done_d    = 1'b0;
    tx_error_d   = 1'b0;
    err_code_d   = err_code_q;

    // Frame bit order after the start bit: data LSB first, parity, stop (1).
    cur_bit = 1'b1;
    if (idx_q < 4'd8) begin
      cur_bit = data_q[idx_q[2:0]];
    end else if (idx_q == 4'd8) begin
      cur_bit = par_q;
    end

    timed = (state_q == S_BITS) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    if (timed) begin
      cnt_d = fall_q ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        ps2clk_oe_d  = 1'b0;
        ps2data_oe_d = 1'b0;
        if (tx_valid) begin
          data_d      = tx_data;
          par_d       = ~^tx_data;
          idx_d       = '0;
          cnt_d       = '0;
          err_code_d  = 2'b00;
          ps2clk_oe_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d        = '0;
          ps2data_oe_d = 1'b1;
          state_d      = S_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == START_LAST) begin
          cnt_d       = '0;
          ps2clk_oe_d = 1'b0;
          state_d     = S_BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BITS: begin
        if (fall_q) begin
          ps2data_oe_d = ~cur_bit;
          idx_d        = idx_q + 1'b1;
          if (idx_q == 4'd9) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fall_q) begin
          if (dat_flt_q.lvl) begin
            tx_error_d = 1'b1;
            err_code_d = 2'b10;
            state_d    = S_FINISH;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_flt_q.lvl && dat_flt_q.lvl) begin
          tx_done_d = 1'b1;
          state_d   = S_FINISH;
        end
      end
      S_FINISH: begin
        ps2clk_oe_d  = 1'b0;
        ps2data_oe_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Device went silent: release the bus and report, unless the frame just completed.
    if (timed && !fall_q && !tx_done_d && (cnt_q == TO_LAST)) begin
      ps2clk_oe_d  = 1'b0;
      ps2data_oe_d = 1'b0;
      tx_error_d   = 1'b1;
      err_code_d   = 2'b01;
      state_d      = S_FINISH;
    end
  end

  // FSM register stage; the latched byte and parity carry no reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      ps2clk_oe_q  <= 1'b0;
      ps2data_oe_q <= 1'b0;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_error_q   <= 1'b0;
      err_code_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      ps2clk_oe_q  <= ps2clk_oe_d;
      ps2data_oe_q <= ps2data_oe_d;
      busy_q       <= busy_d;
      tx_done_q    <= tx_done_d;
      tx_error_q   <= tx_error_d;
      err_code_q   <= err_code_d;
    end
    data_q <= data_d;
    par_q  <= par_d;
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = busy_q;
  assign ps2clk_oe  = ps2clk_oe_q;
  assign ps2data_oe = ps2data_oe_q;
  assign tx_done    = tx_done_q;
  assign tx_error   = tx_error_q;
  assign err_code   = err_code_q;

endmodule
